i2s_tx_stream: RTL and testbench

Parametrised I2S/left-justified stereo transmitter with a stereo-pair input FIFO and a valid/ready input. It generates BCLK, LRCLK and SDATA as registered outputs entirely in the `clk` domain, with no derived clocks. It replaces the fixed 24-bit single-word sender in the audio output path. Upstream RAM/DMA logic pushes stereo pairs; the board codec or DAC consumes the serial stream.

---
 rtl/i2s_tx_stream.sv | 198 +++++++++++++++++++
 tb/tb_i2s_tx_stream.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_stream.sv
// I2S / left-justified stereo transmitter with a stereo-pair input FIFO; bclk, lrclk and sdata are generated in the clk domain.
// Optional macro I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter.
module i2s_tx_stream #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          mode,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_left,
  input  logic [DATA_WIDTH-1:0]         s_right,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   underrun_count,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(2 * SLOT_WIDTH);
  localparam int KW = BW - 1;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] BC_LAST  = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         count;
  logic                  fifo_full, fifo_empty, push, pop;

  logic [DW-1:0]         div_cnt;
  logic [BW-1:0]         bc, bc_next;
  logic                  bclk_q, lrclk_q, sdata_q, underrun_q;
  logic                  frame_active;
  logic                  mode_q, mode_next;
  logic [DATA_WIDTH-1:0] word_l, word_r, word_l_next, word_r_next;

  logic                  div_wrap, fall, frame_edge, stop_now, frame_start, underrun_set;
  logic                  lr_next, tx_bit;
  logic [KW-1:0]         k;
  logic [IW-1:0]         idx;
  int                    kd;

  assign fifo_full  = (count == LW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign s_ready    = !fifo_full;
  assign push       = s_valid && s_ready;
  assign fifo_level = count;

  assign bclk     = bclk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= s_left;
      mem_r[wr_ptr] <= s_right;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A frame edge is the fall event that begins bc=0; a stop request ends the run there instead.
  always_comb begin
    state_next = state;
    div_wrap   = (div_cnt == DIV_LAST);
    fall       = (state != IDLE) && div_wrap && bclk_q;
    frame_edge = fall && (!frame_active || (bc == BC_LAST));

    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = STOP;
      STOP: begin
        if (enable)          state_next = RUN;
        else if (frame_edge) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    stop_now     = (state == STOP) && !enable && frame_edge;
    frame_start  = frame_edge && !stop_now;
    pop          = frame_start && !fifo_empty;
    underrun_set = frame_start && fifo_empty;
  end

  // Serial bit for the slot position being entered at this fall event.
  always_comb begin
    bc_next     = frame_start ? '0 : bc + BW'(1);
    word_l_next = word_l;
    word_r_next = word_r;
    mode_next   = mode_q;
    if (frame_start) begin
      word_l_next = fifo_empty ? '0 : mem_l[rd_ptr];
      word_r_next = fifo_empty ? '0 : mem_r[rd_ptr];
      mode_next   = mode;
    end

    lr_next = bc_next[BW-1];
    k       = bc_next[KW-1:0];
    kd      = int'(k) - (mode_next ? 0 : 1);
    idx     = '0;
    tx_bit  = 1'b0;
    if (kd >= 0 && kd < DATA_WIDTH) begin
      idx    = IW'(DATA_WIDTH - 1 - kd);
      tx_bit = lr_next ? word_r_next[idx] : word_l_next[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      bclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      underrun_q   <= 1'b0;
      bc           <= '0;
      frame_active <= 1'b0;
      mode_q       <= 1'b0;
      word_l       <= '0;
      word_r       <= '0;
    end else begin
      underrun_q <= underrun_set;
      if (state == IDLE || stop_now) begin
        div_cnt      <= '0;
        bclk_q       <= 1'b0;
        lrclk_q      <= 1'b0;
        sdata_q      <= 1'b0;
        bc           <= '0;
        frame_active <= 1'b0;
      end else begin
        div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
        if (div_wrap) bclk_q <= !bclk_q;
        if (fall) begin
          bc           <= bc_next;
          frame_active <= 1'b1;
          lrclk_q      <= lr_next;
          sdata_q      <= tx_bit;
        end
        if (frame_start) begin
          word_l <= word_l_next;
          word_r <= word_r_next;
          mode_q <= mode_next;
        end
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     urun_cnt <= 16'h0000;
    else if (underrun_set && urun_cnt != 16'hFFFF)  urun_cnt <= urun_cnt + 16'd1;
  end

  assign underrun_count = urun_cnt;
`else
  assign underrun_count = 16'h0000;
`endif

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Directed self-checking bench for i2s_tx_stream at default parameters.
module tb_i2s_tx_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_left = '0;
  logic [23:0] s_right = '0;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic [15:0] underrun_count;
  logic        bclk, lrclk, sdata;

  int assertions = 0;
  int failures   = 0;

  i2s_tx_stream #(
    .DATA_WIDTH(24), .SLOT_WIDTH(32), .BCLK_DIV(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .fifo_level(fifo_level), .underrun(underrun), .underrun_count(underrun_count),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    enable  = 1'b0;
    s_valid = 1'b0;
    mode    = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_fall();
    logic b0;
    b0 = bclk;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (b0 && !bclk) return;
      b0 = bclk;
    end
    assertions++;
    failures++;
    $display("[TB] FAIL bclk_fall_timeout: got no bclk fall in 40 cycles, expected one");
  endtask

  // Records sdata/lrclk after 64 consecutive fall events, first bit in the MSB.
  task automatic capture_frame(input int act_at, input int act,
                               output logic [63:0] sd, output logic [63:0] lr);
    sd = '0;
    lr = '0;
    for (int i = 0; i < 64; i++) begin
      wait_fall();
      sd = {sd[62:0], sdata};
      lr = {lr[62:0], lrclk};
      if (i == act_at) begin
        if (act == 1)      mode = ~mode;
        else if (act == 2) enable = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    assertions++; if (bclk !== 1'b0) begin failures++; $display("[TB] FAIL reset_bclk: got %b, expected 0", bclk); end
    assertions++; if (lrclk !== 1'b0) begin failures++; $display("[TB] FAIL reset_lrclk: got %b, expected 0", lrclk); end
    assertions++; if (sdata !== 1'b0) begin failures++; $display("[TB] FAIL reset_sdata: got %b, expected 0", sdata); end
    assertions++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_underrun: got %b, expected 0", underrun); end
    assertions++; if (underrun_count !== 16'h0000) begin failures++; $display("[TB] FAIL reset_underrun_count: got %h, expected 0000", underrun_count); end
    assertions++; if (fifo_level !== 3'd0) begin failures++; $display("[TB] FAIL reset_fifo_level: got %0d, expected 0", fifo_level); end
    assertions++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_s_ready: got %b, expected 1", s_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i2s_frame();
    logic [63:0] sd, lr;
    logic        p, found;
    int          cyc;
    do_reset();
    mode = 1'b0;
    push_pair(24'hA5A5A5, 24'h5A5A5A);
    assertions++; if (fifo_level !== 3'd1) begin failures++; $display("[TB] FAIL i2s_level_after_push: got %0d, expected 1", fifo_level); end
    enable = 1'b1;
    capture_frame(-1, 0, sd, lr);
    assertions++; if (sd[63:32] !== 32'h52D2D280) begin failures++; $display("[TB] FAIL i2s_left_slot: got %h, expected 52d2d280", sd[63:32]); end
    assertions++; if (sd[31:0] !== 32'h2D2D2D00) begin failures++; $display("[TB] FAIL i2s_right_slot: got %h, expected 2d2d2d00", sd[31:0]); end
    assertions++; if (lr !== 64'h00000000FFFFFFFF) begin failures++; $display("[TB] FAIL i2s_lrclk_pattern: got %h, expected 00000000ffffffff", lr); end
    assertions++; if (fifo_level !== 3'd0) begin failures++; $display("[TB] FAIL i2s_level_after_pop: got %0d, expected 0", fifo_level); end
    found = 1'b0;
    p = lrclk;
    for (int n = 0; n < 600 && !found; n++) begin
      @(negedge clk);
      if (!p && lrclk) found = 1'b1;
      p = lrclk;
    end
    found = 1'b0;
    cyc = 0;
    for (int n = 0; n < 600 && !found; n++) begin
      @(negedge clk);
      cyc++;
      if (!p && lrclk) found = 1'b1;
      p = lrclk;
    end
    assertions++; if (cyc !== 256) begin failures++; $display("[TB] FAIL i2s_lrclk_period: got %0d, expected 256", cyc); end
    enable = 1'b0;
  endtask

  task automatic test_left_justified();
    logic [63:0] sd, lr;
    do_reset();
    mode = 1'b1;
    push_pair(24'hA5A5A5, 24'h5A5A5A);
    enable = 1'b1;
    // Mode is flipped at bc=5; the frame must stay left-justified.
    capture_frame(5, 1, sd, lr);
    assertions++; if (sd[63] !== 1'b1) begin failures++; $display("[TB] FAIL lj_msb_at_bc0: got %b, expected 1", sd[63]); end
    assertions++; if (sd[63:32] !== 32'hA5A5A500) begin failures++; $display("[TB] FAIL lj_left_slot: got %h, expected a5a5a500", sd[63:32]); end
    assertions++; if (sd[31:0] !== 32'h5A5A5A00) begin failures++; $display("[TB] FAIL lj_right_slot: got %h, expected 5a5a5a00", sd[31:0]); end
    assertions++; if (lr !== 64'h00000000FFFFFFFF) begin failures++; $display("[TB] FAIL lj_lrclk_pattern: got %h, expected 00000000ffffffff", lr); end
    enable = 1'b0;
  endtask

  task automatic test_underrun();
    int   pulses, high, ones;
    logic prev;
    logic [15:0] exp_cnt;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    do_reset();
    mode   = 1'b0;
    pulses = 0;
    high   = 0;
    ones   = 0;
    prev   = 1'b0;
    enable = 1'b1;
    for (int n = 0; n < 768; n++) begin
      @(negedge clk);
      if (underrun) high++;
      if (underrun && !prev) pulses++;
      prev = underrun;
      if (sdata) ones++;
    end
    assertions++; if (pulses !== 3) begin failures++; $display("[TB] FAIL underrun_pulses: got %0d, expected 3", pulses); end
    assertions++; if (high !== 3) begin failures++; $display("[TB] FAIL underrun_width: got %0d high cycles, expected 3", high); end
    assertions++; if (ones !== 0) begin failures++; $display("[TB] FAIL underrun_sdata: got %0d ones, expected 0", ones); end
    assertions++; if (underrun_count !== exp_cnt) begin failures++; $display("[TB] FAIL underrun_count: got %0d, expected %0d", underrun_count, exp_cnt); end
    enable = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [63:0] sd, lr;
    logic [23:0] lv [4];
    logic [23:0] rv [4];
    lv = '{24'h123456, 24'hABCDEF, 24'h0F0F0F, 24'h800001};
    rv = '{24'h654321, 24'hFEDCBA, 24'hF0F0F0, 24'h100008};
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < 3; i++) push_pair(lv[i], rv[i]);
    assertions++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_after3: got %b, expected 1", s_ready); end
    assertions++; if (fifo_level !== 3'd3) begin failures++; $display("[TB] FAIL full_level_after3: got %0d, expected 3", fifo_level); end
    push_pair(lv[3], rv[3]);
    assertions++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_after4: got %b, expected 0", s_ready); end
    assertions++; if (fifo_level !== 3'd4) begin failures++; $display("[TB] FAIL full_level_after4: got %0d, expected 4", fifo_level); end
    s_left  = 24'hFFFFFF;
    s_right = 24'h000000;
    s_valid = 1'b1;
    repeat (4) @(negedge clk);
    s_valid = 1'b0;
    assertions++; if (fifo_level !== 3'd4) begin failures++; $display("[TB] FAIL full_fifth_rejected: got %0d, expected 4", fifo_level); end
    enable = 1'b1;
    capture_frame(-1, 0, sd, lr);
    assertions++; if (fifo_level !== 3'd3) begin failures++; $display("[TB] FAIL full_level_after_pop: got %0d, expected 3", fifo_level); end
    assertions++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_after_pop: got %b, expected 1", s_ready); end
    assertions++; if (sd !== 64'h1234560065432100) begin failures++; $display("[TB] FAIL full_frame1_data: got %h, expected 1234560065432100", sd); end
    capture_frame(-1, 0, sd, lr);
    assertions++; if (sd !== 64'hABCDEF00FEDCBA00) begin failures++; $display("[TB] FAIL full_frame2_data: got %h, expected abcdef00fedcba00", sd); end
    assertions++; if (fifo_level !== 3'd2) begin failures++; $display("[TB] FAIL full_level_frame2: got %0d, expected 2", fifo_level); end
    enable = 1'b0;
  endtask

  task automatic test_stop();
    logic [63:0] sd, lr;
    int ones, pulses;
    do_reset();
    mode = 1'b1;
    push_pair(24'h0F0F0F, 24'hF0F0F0);
    push_pair(24'h800001, 24'h100008);
    enable = 1'b1;
    capture_frame(10, 2, sd, lr);
    assertions++; if (sd !== 64'h0F0F0F00F0F0F000) begin failures++; $display("[TB] FAIL stop_frame_completes: got %h, expected 0f0f0f00f0f0f000", sd); end
    assertions++; if (lr !== 64'h00000000FFFFFFFF) begin failures++; $display("[TB] FAIL stop_lrclk_pattern: got %h, expected 00000000ffffffff", lr); end
    repeat (8) @(negedge clk);
    ones   = 0;
    pulses = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bclk || lrclk || sdata) ones++;
      if (underrun) pulses++;
    end
    assertions++; if (ones !== 0) begin failures++; $display("[TB] FAIL stop_outputs_quiet: got %0d active cycles, expected 0", ones); end
    assertions++; if (pulses !== 0) begin failures++; $display("[TB] FAIL stop_no_underrun: got %0d, expected 0", pulses); end
    assertions++; if (fifo_level !== 3'd1) begin failures++; $display("[TB] FAIL stop_no_pop: got %0d, expected 1", fifo_level); end
  endtask

  task automatic test_async_reset();
    int ones;
    do_reset();
    mode = 1'b1;
    push_pair(24'h0F0F0F, 24'hF0F0F0);
    push_pair(24'h800001, 24'h100008);
    enable = 1'b1;
    for (int i = 0; i < 21; i++) wait_fall();
    for (int n = 0; n < 8 && !bclk; n++) @(negedge clk);
    assertions++; if (bclk !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre_bclk: got %b, expected 1", bclk); end
    assertions++; if (fifo_level !== 3'd1) begin failures++; $display("[TB] FAIL areset_pre_level: got %0d, expected 1", fifo_level); end
    #2;
    rst_n = 1'b0;
    #1;
    assertions++; if (bclk !== 1'b0) begin failures++; $display("[TB] FAIL areset_bclk: got %b, expected 0", bclk); end
    assertions++; if (lrclk !== 1'b0) begin failures++; $display("[TB] FAIL areset_lrclk: got %b, expected 0", lrclk); end
    assertions++; if (sdata !== 1'b0) begin failures++; $display("[TB] FAIL areset_sdata: got %b, expected 0", sdata); end
    assertions++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL areset_underrun: got %b, expected 0", underrun); end
    assertions++; if (fifo_level !== 3'd0) begin failures++; $display("[TB] FAIL areset_level: got %0d, expected 0", fifo_level); end
    assertions++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL areset_s_ready: got %b, expected 1", s_ready); end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ones = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bclk) ones++;
    end
    assertions++; if (ones !== 0) begin failures++; $display("[TB] FAIL areset_idle_after: got %0d bclk-high cycles, expected 0", ones); end
  endtask

  initial begin
    $display("[TB] starting i2s_tx_stream bench");
    test_reset();
    test_i2s_frame();
    test_left_justified();
    test_underrun();
    test_fifo_full();
    test_stop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
